// File: rtl/quant_qt_qscale_stream.sv
// Streaming 8x8 coefficient quantizer: q = (coef << SHIFT) / (qscale * qmat[idx]).
// Two register stages (divisor/numerator, then rounded+saturated quotient) behind a valid/ready stream.
module quant_qt_qscale_stream #(
  parameter int LANES = 8,
  parameter int IN_W  = 32,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int ROUND = 0
) (
  input  logic                   CLOCK,
  input  logic                   RESET,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [LANES*IN_W-1:0]  IN_DATA,
  input  logic [31:0]            QSCALE,
  input  logic                   IS_Y,
  input  logic [64*32-1:0]       Y_QMAT,
  input  logic [64*32-1:0]       C_QMAT,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [LANES*OUT_W-1:0] OUT_DATA,
  output logic                   OUT_LAST,
  output logic                   ERR
);

  localparam int BEATS = 64 / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = $clog2(LANES);
  localparam int NW    = IN_W + SHIFT;
  localparam int AW    = ((NW > 64) ? NW : 64) + 1;

  localparam logic [CW-1:0] C_LASTB = CW'(BEATS - 1);
  localparam logic [AW-1:0] C_LIM   = {{(AW-1){1'b0}}, 1'b1} << (OUT_W - 1);
  localparam logic [AW-1:0] C_MAXP  = C_LIM - 1'b1;

  logic [CW-1:0]          r_cnt;
  logic signed [31:0]     r_qs;
  logic                   r_isy;

  logic                   r_s1_v;
  logic signed [NW-1:0]   r_s1_num [LANES];
  logic [63:0]            r_s1_div [LANES];
  logic [LANES-1:0]       r_s1_bad;
  logic [CW-1:0]          r_s1_beat;

  logic                   r_ovalid;
  logic                   r_olast;
  logic                   r_err;
  logic [LANES*OUT_W-1:0] r_odata;

  logic                   w_adv;
  logic                   w_s1_ld;
  logic                   w_acc;
  logic                   w_first;
  logic signed [31:0]     w_qs;
  logic                   w_isy;
  logic [5:0]             w_idx [LANES];
  logic signed [31:0]     w_qm  [LANES];
  logic signed [NW-1:0]   w_num [LANES];
  logic [63:0]            w_div [LANES];
  logic [LANES-1:0]       w_bad;
  logic [OUT_W-1:0]       w_q   [LANES];

  // Magnitude-domain divide so truncation and half-away rounding share one path,
  // then the sign is reapplied with an asymmetric clamp.
  function automatic logic [OUT_W-1:0] f_quant(input logic signed [NW-1:0] n,
                                               input logic [63:0] d,
                                               input logic bad);
    logic             neg;
    logic [NW-1:0]    mag_n;
    logic [AW-1:0]    mag;
    logic [AW-1:0]    dd;
    logic [AW-1:0]    num;
    logic [AW-1:0]    q;
    logic [OUT_W-1:0] res;
    neg   = n[NW-1];
    mag_n = neg ? -n : n;
    mag   = AW'(mag_n);
    dd    = AW'(d);
    num   = (ROUND != 0) ? mag + (dd >> 1) : mag;
    q     = (bad || dd == '0) ? '0 : num / dd;
    if (!neg) res = (q > C_MAXP) ? C_MAXP[OUT_W-1:0] : q[OUT_W-1:0];
    else      res = (q >= C_LIM) ? C_LIM[OUT_W-1:0]  : -q[OUT_W-1:0];
    return res;
  endfunction

  always_comb begin
    w_adv   = OUT_READY || !r_ovalid;
    w_s1_ld = w_adv || !r_s1_v;
    w_acc   = IN_VALID && w_s1_ld;
    w_first = (r_cnt == '0);
    w_qs    = w_first ? $signed(QSCALE) : r_qs;
    w_isy   = w_first ? IS_Y : r_isy;
  end

  assign IN_READY = w_s1_ld;

  // Beat 0 sees the live QSCALE/IS_Y; later beats use the copy latched on beat 0.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_idx[l] = 6'((32'(r_cnt) << LW) + l);
      w_qm[l]  = $signed(w_isy ? Y_QMAT[{w_idx[l], 5'd0} +: 32]
                               : C_QMAT[{w_idx[l], 5'd0} +: 32]);
      w_bad[l] = (w_qs <= 0) || (w_qm[l] <= 0);
      w_div[l] = 64'(w_qs) * 64'(w_qm[l]);
      w_num[l] = NW'($signed(IN_DATA[l*IN_W +: IN_W])) <<< SHIFT;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_cnt     <= '0;
      r_qs      <= '0;
      r_isy     <= 1'b0;
      r_s1_v    <= 1'b0;
      r_s1_bad  <= '0;
      r_s1_beat <= '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        r_s1_num[l] <= '0;
        r_s1_div[l] <= '0;
      end
    end else begin
      if (w_s1_ld) r_s1_v <= IN_VALID;
      if (w_acc) begin
        r_cnt <= (r_cnt == C_LASTB) ? '0 : r_cnt + 1'b1;
        if (w_first) begin
          r_qs  <= $signed(QSCALE);
          r_isy <= IS_Y;
        end
        r_s1_beat <= r_cnt;
        r_s1_bad  <= w_bad;
        for (int unsigned l = 0; l < LANES; l++) begin
          r_s1_num[l] <= w_num[l];
          r_s1_div[l] <= w_div[l];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      w_q[l] = f_quant(r_s1_num[l], r_s1_div[l], r_s1_bad[l]);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_ovalid <= 1'b0;
      r_olast  <= 1'b0;
      r_err    <= 1'b0;
      r_odata  <= '0;
    end else if (w_adv) begin
      r_ovalid <= r_s1_v;
      r_olast  <= r_s1_v && (r_s1_beat == C_LASTB);
      if (r_s1_v) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          r_odata[l*OUT_W +: OUT_W] <= w_q[l];
        end
        if (|r_s1_bad) r_err <= 1'b1;
      end
    end
  end

  assign OUT_VALID = r_ovalid;
  assign OUT_DATA  = r_odata;
  assign OUT_LAST  = r_olast;
  assign ERR       = r_err;

endmodule

// File: tb/tb_quant_qt_qscale_stream.sv
// Scoreboard bench: two quantizer instances (truncate/32-bit and round/16-bit) share one stream.
module tb_quant_qt_qscale_stream;

  localparam int L = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic [L*32-1:0] in_data;
  logic [31:0]    qscale;
  logic           is_y;
  logic [2047:0]  yq;
  logic [2047:0]  cq;
  logic           out_ready;

  logic           a_in_ready, a_out_valid, a_out_last, a_err;
  logic [L*32-1:0] a_out_data;
  logic           b_in_ready, b_out_valid, b_out_last, b_err;
  logic [L*16-1:0] b_out_data;

  always #5 clk = ~clk;

  quant_qt_qscale_stream #(.LANES(L), .IN_W(32), .OUT_W(32), .SHIFT(2), .ROUND(0)) u_a (
    .CLOCK(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_READY(a_in_ready),
    .IN_DATA(in_data), .QSCALE(qscale), .IS_Y(is_y), .Y_QMAT(yq), .C_QMAT(cq),
    .OUT_VALID(a_out_valid), .OUT_READY(out_ready), .OUT_DATA(a_out_data),
    .OUT_LAST(a_out_last), .ERR(a_err));

  quant_qt_qscale_stream #(.LANES(L), .IN_W(32), .OUT_W(16), .SHIFT(2), .ROUND(1)) u_b (
    .CLOCK(clk), .RESET(rst_n), .IN_VALID(in_valid), .IN_READY(b_in_ready),
    .IN_DATA(in_data), .QSCALE(qscale), .IS_Y(is_y), .Y_QMAT(yq), .C_QMAT(cq),
    .OUT_VALID(b_out_valid), .OUT_READY(out_ready), .OUT_DATA(b_out_data),
    .OUT_LAST(b_out_last), .ERR(b_err));

  typedef struct {
    logic [L*32-1:0] a;
    logic [L*16-1:0] b;
    bit              last;
    bit              err;
  } exp_t;

  exp_t   sb[$];
  int     pop_cyc[$];
  int     n_cmp = 0;
  int     n_mis = 0;
  int     cyc = 0;
  int     or_mode = 0;

  int     m_cnt;
  longint m_qs;
  bit     m_isy;
  bit     m_err;
  int     hs_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Quantizer reference: plain integer arithmetic on 64-bit values.
  function automatic longint ref_q(longint coef, longint qs, longint qm, int rnd, int ow);
    longint n, d, a, q, hi, lo;
    if (qs <= 0 || qm <= 0) return 0;
    n = coef * 4;
    d = qs * qm;
    if (rnd == 0) q = n / d;
    else begin
      a = (n < 0) ? -n : n;
      q = (a + d / 2) / d;
      if (n < 0) q = -q;
    end
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -hi - 1;
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q;
  endfunction

  task automatic push_expected();
    exp_t   e;
    longint coef, qm, qa, qb;
    int     idx;
    if (m_cnt == 0) begin
      m_qs  = longint'($signed(qscale));
      m_isy = is_y;
    end
    for (int l = 0; l < L; l++) begin
      idx  = m_cnt * L + l;
      coef = longint'($signed(in_data[l*32 +: 32]));
      qm   = m_isy ? longint'($signed(yq[idx*32 +: 32])) : longint'($signed(cq[idx*32 +: 32]));
      if (m_qs <= 0 || qm <= 0) m_err = 1'b1;
      qa = ref_q(coef, m_qs, qm, 0, 32);
      qb = ref_q(coef, m_qs, qm, 1, 16);
      e.a[l*32 +: 32] = qa[31:0];
      e.b[l*16 +: 16] = qb[15:0];
    end
    e.last = (m_cnt == L - 1);
    e.err  = m_err;
    sb.push_back(e);
    m_cnt = (m_cnt + 1) % L;
  endtask

  // Monitor: pops on every output handshake; also checks hold-stability under backpressure.
  exp_t            mon_e;
  logic            held;
  logic [L*32+1:0] prev_a;
  logic [L*16+1:0] prev_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      held <= 1'b0;
    end else begin
      if (held) begin
        check("hold_a", 384'({a_out_valid, a_out_last, a_out_data}), 384'(prev_a));
        check("hold_b", 384'({b_out_valid, b_out_last, b_out_data}), 384'(prev_b));
      end
      if (a_out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_beat: got output beat expected none (t=%0t)", $time);
        end else begin
          mon_e = sb.pop_front();
          pop_cyc.push_back(cyc);
          check("data_a", 384'(a_out_data), 384'(mon_e.a));
          check("valid_b", 384'(b_out_valid), 384'(1));
          check("data_b", 384'(b_out_data), 384'(mon_e.b));
          check("last_a", 384'(a_out_last), 384'(mon_e.last));
          check("last_b", 384'(b_out_last), 384'(mon_e.last));
          check("err_a", 384'(a_err), 384'(mon_e.err));
          check("err_b", 384'(b_err), 384'(mon_e.err));
        end
      end
      held   <= a_out_valid && !out_ready;
      prev_a <= {a_out_valid, a_out_last, a_out_data};
      prev_b <= {b_out_valid, b_out_last, b_out_data};
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (or_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send_beat(input logic [L*32-1:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (a_in_ready && b_in_ready) begin
        push_expected();
        hs_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    n_mis++;
    $display("FAIL accept_timeout: got no IN_READY expected accept within 300 cycles");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(posedge clk);
    #1;
    check("drain", 384'(sb.size()), 384'(0));
  endtask

  function automatic logic [31:0] rnd_coef();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0:       return 32'($signed($urandom_range(0, 400)) - 200);
      1:       return $urandom;
      2:       return 32'd0;
      default: return 32'($signed($urandom_range(0, 1 << 22)) - (1 << 21));
    endcase
  endfunction

  function automatic logic [L*32-1:0] rnd_beat();
    logic [L*32-1:0] d;
    for (int l = 0; l < L; l++) d[l*32 +: 32] = rnd_coef();
    return d;
  endfunction

  task automatic send_rand_block(input int nb);
    for (int b = 0; b < nb; b++) send_beat(rnd_beat());
  endtask

  task automatic do_reset_check(input string tag);
    @(negedge clk);
    check({tag, "_valid_a"}, 384'(a_out_valid), 384'(0));
    check({tag, "_valid_b"}, 384'(b_out_valid), 384'(0));
    check({tag, "_last_a"}, 384'(a_out_last), 384'(0));
    check({tag, "_data_a"}, 384'(a_out_data), 384'(0));
    check({tag, "_err_a"}, 384'(a_err), 384'(0));
    check({tag, "_err_b"}, 384'(b_err), 384'(0));
  endtask

  logic [L*32-1:0] d;
  int              hs0;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    qscale = 32'd0; is_y = 1'b0; yq = '0; cq = '0;
    m_cnt = 0; m_qs = 0; m_isy = 1'b0; m_err = 1'b0;
    repeat (3) @(posedge clk);
    do_reset_check("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain block: 100 << 2 / (2*4) = 50 everywhere, no bubbles.
    for (int i = 0; i < 64; i++) yq[i*32 +: 32] = 32'd4;
    for (int i = 0; i < 64; i++) cq[i*32 +: 32] = 32'd3;
    qscale = 32'd2; is_y = 1'b1;
    for (int l = 0; l < L; l++) d[l*32 +: 32] = 32'd100;
    pop_cyc.delete();
    for (int b = 0; b < 8; b++) begin
      send_beat(d);
      if (b == 0) hs0 = hs_cyc;
    end
    drain();
    check("t1_beats", 384'(pop_cyc.size()), 384'(8));
    if (pop_cyc.size() >= 8) begin
      check("t1_latency", 384'(pop_cyc[0] - hs0), 384'(2));
      check("t1_nobubble", 384'(pop_cyc[7] - pop_cyc[0]), 384'(7));
    end

    // Rounding: +-13 with qscale 2, qmat 4.
    for (int l = 0; l < L; l++) d[l*32 +: 32] = (l % 2 == 0) ? -32'sd13 : 32'sd13;
    for (int b = 0; b < 8; b++) send_beat(d);

    // Saturation at +-2^20 with unit divisor.
    qscale = 32'd1;
    for (int i = 0; i < 64; i++) yq[i*32 +: 32] = 32'd1;
    for (int l = 0; l < L; l++) d[l*32 +: 32] = (l % 2 == 0) ? (32'sd1 <<< 20) : -(32'sd1 <<< 20);
    for (int b = 0; b < 8; b++) send_beat(d);
    drain();

    // Per-block latching: mid-block QSCALE/IS_Y changes are ignored until next beat 0.
    for (int i = 0; i < 64; i++) yq[i*32 +: 32] = 32'($urandom_range(1, 16));
    for (int i = 0; i < 64; i++) cq[i*32 +: 32] = 32'($urandom_range(17, 40));
    qscale = 32'd2; is_y = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (b == 3) begin qscale = 32'd8; is_y = 1'b0; end
      for (int l = 0; l < L; l++) d[l*32 +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
      send_beat(d);
    end
    send_rand_block(8);
    drain();

    // Backpressure: 3 stalled cycles across two back-to-back blocks.
    or_mode = 2;
    fork
      send_rand_block(16);
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", 384'(a_in_ready), 384'(0));
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Zero chroma entry: lane 5 of beat 0 yields 0 and ERR sticks.
    qscale = 32'd3; is_y = 1'b0;
    cq[5*32 +: 32] = 32'd0;
    send_rand_block(8);
    cq[5*32 +: 32] = 32'd7;
    is_y = 1'b1;
    send_rand_block(8);
    is_y = 1'b0;
    send_rand_block(8);
    drain();
    check("err_sticky", 384'(a_err), 384'(1));

    // Reset after beat 4 of a block; next beat is beat 0 with new qscale.
    send_rand_block(5);
    rst_n = 1'b0; in_valid = 1'b0;
    sb.delete();
    m_cnt = 0; m_err = 1'b0;
    do_reset_check("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    qscale = 32'd5; is_y = 1'b1;
    send_rand_block(8);
    drain();

    // Randomized traffic with gaps, random backpressure and occasional bad divisors.
    or_mode = 1;
    for (int blk = 0; blk < 25; blk++) begin
      for (int i = 0; i < 64; i++) begin
        yq[i*32 +: 32] = ($urandom_range(0, 60) == 0) ? -32'sd3 : 32'($urandom_range(1, 64));
        cq[i*32 +: 32] = ($urandom_range(0, 60) == 0) ? 32'd0 : 32'($urandom_range(1, 64));
      end
      for (int b = 0; b < 8; b++) begin
        qscale = ($urandom_range(0, 30) == 0) ? 32'd0 : 32'($urandom_range(1, 32));
        is_y   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 4) == 0) begin
          in_valid = 1'b0;
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        send_beat(rnd_beat());
      end
    end
    or_mode = 2;
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/quant_qt_qscale_stream.md
Name: quant_qt_qscale_stream

Overview:
Streaming, parametrised ProRes coefficient quantizer. It sits between the DCT output and the entropy coder. An 8x8 coefficient block arrives as BEATS = 64/LANES beats of LANES coefficients, over a valid/ready handshake. Each coefficient is computed as (coef << SHIFT) / (qscale * qmat[idx]), with selectable rounding, saturation, per-block parameter latching, a last-beat flag and a sticky divide error.

Parameters:
LANES, 8, coefficients per beat; legal values 1, 2, 4, 8, 16, 32, 64 (BEATS = 64/LANES)
IN_W, 32, signed input coefficient width
OUT_W, 32, signed output width; results are clamped to this width
SHIFT, 2, left shift applied to the numerator before division
ROUND, 0, 0 = truncate toward zero; 1 = round half away from zero

Ports:
CLOCK  in  1  clock; all logic on posedge
RESET  in  1  asynchronous, active-low reset
IN_VALID  in  1  beat valid
IN_READY  out  1  beat accepted when IN_VALID && IN_READY
IN_DATA  in  LANES x IN_W signed  coefficients; lane l carries index beat*LANES+l (raster order)
QSCALE  in  32 signed  quantiser scale; sampled on beat 0 only
IS_Y  in  1  1 = use Y_QMAT, 0 = use C_QMAT; sampled on beat 0 only
Y_QMAT  in  64 x 32 signed  luma matrix; static while a block is in flight
C_QMAT  in  64 x 32 signed  chroma matrix; static while a block is in flight
OUT_VALID  out  1  result beat valid
OUT_READY  in  1  downstream ready
OUT_DATA  out  LANES x OUT_W signed  quantised coefficients
OUT_LAST  out  1  high with the final beat (beat BEATS-1) of a block
ERR  out  1  sticky flag: a divisor <= 0 occurred

Behaviour:
- Reset (RESET=0, asynchronous): OUT_VALID=0, OUT_DATA=0, OUT_LAST=0, ERR=0, beat counter=0, pipeline valids=0, latched qscale/is_y=0. Reset is legal mid-block; the partial block is discarded and the next accepted beat is beat 0.
- Pipeline has two stages.
  - S1 registers: the shifted numerators (width IN_W+SHIFT), the divisors qscale*qmat[idx] (64-bit product), the beat index and the last flag.
  - S2 registers: quotient after rounding and saturation, presented on OUT_DATA.
  - Latency from input accept to OUT_VALID is 2 cycles with no stall.
  - Throughput is 1 beat per cycle.
- Stall rule: advance = OUT_READY || !OUT_VALID.
  - S2 loads when advance is true. S1 loads when advance || !s1_valid.
  - IN_READY = advance || !s1_valid (combinational, no skid buffer).
  - OUT_DATA, OUT_VALID and OUT_LAST must hold stable while OUT_VALID && !OUT_READY.
- Beat counter: increments on each accept and wraps from BEATS-1 to 0.
  - On an accept with counter=0, the S1 divisor uses the live QSCALE and IS_Y, and these values are latched.
  - Beats 1..BEATS-1 use the latched values; changes on QSCALE/IS_Y mid-block are ignored.
- OUT_LAST = 1 exactly on the output beat whose index = BEATS-1. With LANES=64, every beat is last.
- Arithmetic:
  - Numerator = sign-extended IN_DATA << SHIFT.
  - ROUND=0: signed division truncating toward zero (C semantics).
  - ROUND=1: q = sign(n) * ((|n| + d/2) / d), with integer division.
  - The result is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Divisor <= 0 (QSCALE <= 0 or qmat entry <= 0): that lane outputs 0 and ERR is set. ERR stays 1 until reset; the stream otherwise continues normally.
- A numerator of 0 always yields 0, including with a zero divisor (ERR is still set).

Test Plan:
- LANES=8, ROUND=0. Block with all IN_DATA=100, QSCALE=2, IS_Y=1, Y_QMAT all 4, OUT_READY=1 -> 8 output beats of 50 (400/8), first at accept+2, OUT_LAST only on beat 7, no bubbles.
- Coefficient -13, QSCALE=2, qmat=4 -> ROUND=0 gives -6 and ROUND=1 gives -7; coefficient 13 gives 6 and 7 respectively.
- OUT_W=16, coefficient 2^20, QSCALE=1, qmat=1 -> 32767; coefficient -2^20 -> -32768.
- Per-block latching: QSCALE changes 2->8 and IS_Y 1->0 at beat 3 -> beats 3..7 still use qscale 2 and Y_QMAT; the next block's beat 0 uses 8 and C_QMAT.
- Backpressure: OUT_READY low for 3 cycles during streaming -> IN_READY drops once both stages are full, output is held stable, no beats are lost or duplicated, and order is preserved across 2 back-to-back blocks.
- C_QMAT[5]=0 with IS_Y=0 -> lane 5 of beat 0 = 0 and ERR=1, which persists over later good blocks; asserting RESET mid-block (beat 4) clears ERR, OUT_VALID and the counter, and the next accepted beat is treated as beat 0.
